// File: rtl/rk8e_dma_bridge.sv
// rk8e_dma_bridge
// ----------------
// Bridges the RK8E disk controller's single-word DMA requests onto the CPU
// memory bus. Each request is carried out as one break cycle:
//   IDLE -> BRK (request the bus) -> MEM (one RAM strobe) [-> RDW] -> ACK.
//
// Disk handshake (4-phase): the disk raises dmaREQ with dmaRD/dmaWR, dmaADDR
// and dmaDOUT stable. The bridge answers with dmaGNT=1 once the word has been
// written, or once dmaDIN holds the read word. The disk then drops dmaREQ,
// the bridge drops dmaGNT, and a new request may start. dmaREQ passes through
// a two-flop synchronizer because it comes from the disk clock domain, so a
// request is acted on two clocks after it is first sampled. The disk
// holds its address/data/direction stable for as long as dmaREQ is high.
//
// Ports
//   clk, reset (async, active low), clear (sync IOCLR, active high)
//   dmaREQ/dmaRD/dmaWR/dmaADDR/dmaDOUT : disk request, direction, address, write data
//   dmaGNT/dmaDIN                      : grant and read data back to the disk
//   brkREQ/brkGNT                      : break-cycle request / grant with the CPU
//   memADDR/memWDATA/memWE/memRE       : synchronous RAM port
//   memRDATA                           : RAM read data, valid one cycle after memRE
//   dmaERR/dmaTMO                      : sticky protocol-error / bus-timeout flags
//   xferCNT                            : count of memory cycles performed (wraps)
//   dbgState                           : current FSM state for observation
module rk8e_dma_bridge #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        dmaREQ,
  input  logic        dmaRD,
  input  logic        dmaWR,
  input  logic [0:14] dmaADDR,
  input  logic [0:11] dmaDOUT,
  output logic        dmaGNT,
  output logic [0:11] dmaDIN,
  output logic        brkREQ,
  input  logic        brkGNT,
  output logic [0:14] memADDR,
  output logic [0:11] memWDATA,
  output logic        memWE,
  output logic        memRE,
  input  logic [0:11] memRDATA,
  output logic        dmaERR,
  output logic        dmaTMO,
  output logic [0:11] xferCNT,
  output logic [2:0]  dbgState
);

  // The BRK counter runs 0 .. TIMEOUT-1, so BRK lasts exactly TIMEOUT cycles
  // when the CPU never grants the bus.
  localparam int TmoWidth = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BRK  = 3'd1,
    MEM  = 3'd2,
    RDW  = 3'd3,
    ACK  = 3'd4
  } stateT;

  stateT state;
  stateT nextState;

  logic                reqMeta;
  logic                reqSync;
  logic [0:14]         addrQ;
  logic [0:11]         dataQ;
  logic                rdQ;
  logic [TmoWidth-1:0] tmoCnt;
  logic [0:11]         dinQ;
  logic                errQ;
  logic                tmoQ;
  logic [0:11]         cntQ;

  logic latchReq;
  logic setErr;
  logic setTmo;

  // Next-state logic. A request with both or neither direction bits set is
  // a protocol error: it is granted straight away without touching memory.
  always_comb begin
    nextState = state;
    latchReq  = 1'b0;
    setErr    = 1'b0;
    setTmo    = 1'b0;
    case (state)
      IDLE: begin
        if (reqSync) begin
          if (dmaRD == dmaWR) begin
            setErr    = 1'b1;
            nextState = ACK;
          end else begin
            latchReq  = 1'b1;
            nextState = BRK;
          end
        end
      end
      BRK: begin
        if (brkGNT) begin
          nextState = MEM;
        end else if (tmoCnt == TmoLast) begin
          setTmo    = 1'b1;
          nextState = ACK;
        end
      end
      MEM:     nextState = rdQ ? RDW : ACK;
      RDW:     nextState = ACK;
      ACK:     if (!reqSync) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      reqMeta <= 1'b0;
      reqSync <= 1'b0;
      addrQ   <= '0;
      dataQ   <= '0;
      rdQ     <= 1'b0;
      tmoCnt  <= '0;
      dinQ    <= '0;
      errQ    <= 1'b0;
      tmoQ    <= 1'b0;
      cntQ    <= '0;
    end else if (clear) begin
      // The synchronizer is flushed too, so a request still high during
      // IOCLR is treated as a fresh one afterwards.
      state   <= IDLE;
      reqMeta <= 1'b0;
      reqSync <= 1'b0;
      tmoCnt  <= '0;
      errQ    <= 1'b0;
      tmoQ    <= 1'b0;
      cntQ    <= '0;
    end else begin
      state   <= nextState;
      reqMeta <= dmaREQ;
      reqSync <= reqMeta;
      if (latchReq) begin
        addrQ <= dmaADDR;
        dataQ <= dmaDOUT;
        rdQ   <= dmaRD;
      end
      // The counter only advances while waiting in BRK; any exit clears it.
      if (state == BRK && nextState == BRK) begin
        tmoCnt <= tmoCnt + TmoWidth'(1);
      end else begin
        tmoCnt <= '0;
      end
      if (state == RDW) dinQ <= memRDATA;
      if (setErr) errQ <= 1'b1;
      if (setTmo) tmoQ <= 1'b1;
      if (state == MEM) cntQ <= cntQ + 12'd1;
    end
  end

  assign brkREQ   = (state == BRK) || (state == MEM) || (state == RDW);
  assign memWE    = (state == MEM) && !rdQ;
  assign memRE    = (state == MEM) && rdQ;
  assign dmaGNT   = (state == ACK);
  assign memADDR  = addrQ;
  assign memWDATA = dataQ;
  assign dmaDIN   = dinQ;
  assign dmaERR   = errQ;
  assign dmaTMO   = tmoQ;
  assign xferCNT  = cntQ;
  assign dbgState = state;

endmodule

// File: tb/tb_rk8e_dma_bridge.sv
// Bench for rk8e_dma_bridge: a synchronous RAM model, a strobe monitor that
// records every memory write, and one task per scenario. Expected writes are
// queued when a request is driven and compared against the recorded ones.
module tb_rk8e_dma_bridge;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        dmaREQ;
  logic        dmaRD;
  logic        dmaWR;
  logic [0:14] dmaADDR;
  logic [0:11] dmaDOUT;
  logic        dmaGNT;
  logic [0:11] dmaDIN;
  logic        brkREQ;
  logic        brkGNT;
  logic [0:14] memADDR;
  logic [0:11] memWDATA;
  logic        memWE;
  logic        memRE;
  logic [0:11] memRDATA = '0;
  logic        dmaERR;
  logic        dmaTMO;
  logic [0:11] xferCNT;
  logic [2:0]  dbgState;

  int checks = 0;
  int errors = 0;

  logic [26:0] expQ[$];
  logic [26:0] obsQ[$];
  int weCnt = 0;
  int reCnt = 0;
  int bothCnt = 0;

  logic [11:0] mem [0:32767];

  rk8e_dma_bridge #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .dmaREQ(dmaREQ), .dmaRD(dmaRD), .dmaWR(dmaWR),
    .dmaADDR(dmaADDR), .dmaDOUT(dmaDOUT),
    .dmaGNT(dmaGNT), .dmaDIN(dmaDIN),
    .brkREQ(brkREQ), .brkGNT(brkGNT),
    .memADDR(memADDR), .memWDATA(memWDATA), .memWE(memWE), .memRE(memRE),
    .memRDATA(memRDATA),
    .dmaERR(dmaERR), .dmaTMO(dmaTMO), .xferCNT(xferCNT), .dbgState(dbgState)
  );

  // ---------------- clock / RAM model / monitor ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (memWE) mem[memADDR] <= memWDATA;
    if (memRE) memRDATA <= mem[memADDR];
  end

  always @(negedge clk) begin
    if (memWE) begin
      obsQ.push_back({memADDR, memWDATA});
      weCnt++;
    end
    if (memRE) reCnt++;
    if (memWE && memRE) bothCnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Raise a request at a falling edge; lat counts rising edges after the one
  // that first samples dmaREQ until dmaGNT is seen high.
  task automatic do_req(input logic rd, input logic wr, input logic [0:14] a,
                        input logic [0:11] d, output int lat, output int brkCyc,
                        output bit got);
    @(negedge clk);
    dmaRD = rd; dmaWR = wr; dmaADDR = a; dmaDOUT = d; dmaREQ = 1'b1;
    lat = 0; brkCyc = 0; got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dmaGNT) begin
        got = 1'b1;
        break;
      end
      if (brkREQ) brkCyc++;
      lat++;
    end
  endtask

  task automatic drop_req(output bit ok);
    dmaREQ = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!dmaGNT) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0; clear = 1'b0; dmaREQ = 1'b0; dmaRD = 1'b0; dmaWR = 1'b0;
    dmaADDR = '0; dmaDOUT = '0; brkGNT = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({brkREQ, dmaGNT, memWE, memRE, dmaERR, dmaTMO} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {brkREQ, dmaGNT, memWE, memRE, dmaERR, dmaTMO});
    end
    checks++;
    if (memADDR !== 15'o0 || memWDATA !== 12'o0) begin
      errors++;
      $display("FAIL reset_mem_bus: got addr %o data %o expected 0/0", memADDR, memWDATA);
    end
    checks++;
    if (dmaDIN !== 12'o0 || xferCNT !== 12'o0) begin
      errors++;
      $display("FAIL reset_regs: got dmaDIN %o xferCNT %o expected 0/0", dmaDIN, xferCNT);
    end
    checks++;
    if (dbgState !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d expected 0", dbgState);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    int lat; int brk; bit got; bit ok; int w0;
    logic [26:0] e; logic [26:0] o;
    brkGNT = 1'b1;
    w0 = weCnt;
    expQ.push_back({15'o00100, 12'o5252});
    do_req(1'b0, 1'b1, 15'o00100, 12'o5252, lat, brk, got);
    checks++;
    if (!got || lat !== 4) begin
      errors++;
      $display("FAIL write_latency: got %0d (grant %0d) expected 4", lat, got);
    end
    checks++;
    if (xferCNT !== 12'o0001) begin
      errors++;
      $display("FAIL write_xfercnt: got %o expected 0001", xferCNT);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (dmaGNT !== 1'b1) begin
      errors++;
      $display("FAIL write_gnt_hold: got %b expected 1", dmaGNT);
    end
    drop_req(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL write_gnt_release: dmaGNT still high, expected low");
    end
    checks++;
    if (weCnt - w0 !== 1) begin
      errors++;
      $display("FAIL write_pulses: got %0d expected 1", weCnt - w0);
    end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      if (obsQ.size() == 0) begin
        errors++;
        $display("FAIL write_data: got no write expected %o", e);
      end else begin
        o = obsQ.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL write_data: got %o expected %o", o, e);
        end
      end
    end
  endtask

  task automatic test_read();
    int lat; int brk; bit got; bit ok; int r0; int w0;
    logic [26:0] e; logic [26:0] o;
    brkGNT = 1'b1;
    expQ.push_back({15'o07777, 12'o1234});
    do_req(1'b0, 1'b1, 15'o07777, 12'o1234, lat, brk, got);
    drop_req(ok);
    e = expQ.pop_front();
    checks++;
    if (obsQ.size() == 0) begin
      errors++;
      $display("FAIL read_preload: got no write expected %o", e);
    end else begin
      o = obsQ.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL read_preload: got %o expected %o", o, e);
      end
    end
    r0 = reCnt; w0 = weCnt;
    do_req(1'b1, 1'b0, 15'o07777, 12'o0000, lat, brk, got);
    checks++;
    if (!got || lat !== 5) begin
      errors++;
      $display("FAIL read_latency: got %0d (grant %0d) expected 5", lat, got);
    end
    checks++;
    if (dmaDIN !== 12'o1234) begin
      errors++;
      $display("FAIL read_data: got %o expected 1234", dmaDIN);
    end
    checks++;
    if (xferCNT !== 12'o0003) begin
      errors++;
      $display("FAIL read_xfercnt: got %o expected 0003", xferCNT);
    end
    drop_req(ok);
    checks++;
    if (reCnt - r0 !== 1 || weCnt !== w0) begin
      errors++;
      $display("FAIL read_strobes: got re %0d we %0d expected 1/0", reCnt - r0, weCnt - w0);
    end
  endtask

  task automatic test_timeout();
    int lat; int brk; bit got; bit ok; int r0; int w0;
    logic [0:11] c0;
    brkGNT = 1'b0;
    r0 = reCnt; w0 = weCnt; c0 = xferCNT;
    do_req(1'b0, 1'b1, 15'o00200, 12'o7070, lat, brk, got);
    checks++;
    if (!got || lat !== 2 + TMO) begin
      errors++;
      $display("FAIL timeout_latency: got %0d (grant %0d) expected %0d", lat, got, 2 + TMO);
    end
    checks++;
    if (brk !== TMO) begin
      errors++;
      $display("FAIL timeout_brk_cycles: got %0d expected %0d", brk, TMO);
    end
    checks++;
    if (dmaTMO !== 1'b1 || brkREQ !== 1'b0) begin
      errors++;
      $display("FAIL timeout_flag: got tmo %b brk %b expected 1/0", dmaTMO, brkREQ);
    end
    checks++;
    if (xferCNT !== c0 || dmaDIN !== 12'o1234) begin
      errors++;
      $display("FAIL timeout_regs: got cnt %o din %o expected %o/1234", xferCNT, dmaDIN, c0);
    end
    drop_req(ok);
    checks++;
    if (reCnt !== r0 || weCnt !== w0) begin
      errors++;
      $display("FAIL timeout_strobes: got re %0d we %0d expected 0/0", reCnt - r0, weCnt - w0);
    end
  endtask

  task automatic test_error();
    int lat; int brk; bit got; bit ok; int r0; int w0;
    logic [0:11] c0;
    brkGNT = 1'b1;
    r0 = reCnt; w0 = weCnt; c0 = xferCNT;
    do_req(1'b1, 1'b1, 15'o00300, 12'o1111, lat, brk, got);
    checks++;
    if (!got || lat !== 2 || brk !== 0) begin
      errors++;
      $display("FAIL error_both: got lat %0d brk %0d grant %0d expected 2/0/1", lat, brk, got);
    end
    checks++;
    if (dmaERR !== 1'b1 || dmaDIN !== 12'o1234 || xferCNT !== c0) begin
      errors++;
      $display("FAIL error_regs: got err %b din %o cnt %o expected 1/1234/%o",
               dmaERR, dmaDIN, xferCNT, c0);
    end
    drop_req(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL error_release: dmaGNT still high, expected low");
    end
    do_req(1'b0, 1'b0, 15'o00300, 12'o1111, lat, brk, got);
    checks++;
    if (!got || lat !== 2 || brk !== 0) begin
      errors++;
      $display("FAIL error_neither: got lat %0d brk %0d grant %0d expected 2/0/1", lat, brk, got);
    end
    drop_req(ok);
    checks++;
    if (reCnt !== r0 || weCnt !== w0) begin
      errors++;
      $display("FAIL error_strobes: got re %0d we %0d expected 0/0", reCnt - r0, weCnt - w0);
    end
  endtask

  task automatic test_early_drop();
    int gntHigh; int w0;
    logic [0:11] c0;
    logic [26:0] e; logic [26:0] o;
    brkGNT = 1'b1;
    w0 = weCnt; c0 = xferCNT; gntHigh = 0;
    expQ.push_back({15'o04321, 12'o6543});
    @(negedge clk);
    dmaRD = 1'b0; dmaWR = 1'b1; dmaADDR = 15'o04321; dmaDOUT = 12'o6543; dmaREQ = 1'b1;
    @(negedge clk);
    dmaREQ = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (dmaGNT) gntHigh++;
    end
    checks++;
    if (gntHigh !== 1) begin
      errors++;
      $display("FAIL early_drop_gnt: got %0d grant cycles expected 1", gntHigh);
    end
    checks++;
    if (weCnt - w0 !== 1 || xferCNT !== c0 + 12'd1) begin
      errors++;
      $display("FAIL early_drop_xfer: got we %0d cnt %o expected 1/%o",
               weCnt - w0, xferCNT, c0 + 12'd1);
    end
    e = expQ.pop_front();
    checks++;
    if (obsQ.size() == 0) begin
      errors++;
      $display("FAIL early_drop_data: got no write expected %o", e);
    end else begin
      o = obsQ.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL early_drop_data: got %o expected %o", o, e);
      end
    end
  endtask

  task automatic test_clear();
    int brkSeen; int w0; int r0;
    brkGNT = 1'b0;
    w0 = weCnt; r0 = reCnt; brkSeen = 0;
    @(negedge clk);
    dmaRD = 1'b0; dmaWR = 1'b1; dmaADDR = 15'o00500; dmaDOUT = 12'o0707; dmaREQ = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (brkREQ) begin
        brkSeen = 1;
        break;
      end
    end
    checks++;
    if (brkSeen != 1) begin
      errors++;
      $display("FAIL clear_brk_entry: got no brkREQ expected 1");
    end
    repeat (3) @(negedge clk);
    clear = 1'b1; dmaREQ = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (dbgState !== 3'd0 || brkREQ !== 1'b0 || dmaGNT !== 1'b0) begin
      errors++;
      $display("FAIL clear_state: got state %0d brk %b gnt %b expected 0/0/0",
               dbgState, brkREQ, dmaGNT);
    end
    checks++;
    if (dmaERR !== 1'b0 || dmaTMO !== 1'b0 || xferCNT !== 12'o0) begin
      errors++;
      $display("FAIL clear_regs: got err %b tmo %b cnt %o expected 0/0/0",
               dmaERR, dmaTMO, xferCNT);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (brkREQ !== 1'b0 || weCnt !== w0 || reCnt !== r0) begin
      errors++;
      $display("FAIL clear_quiet: got brk %b we %0d re %0d expected 0/0/0",
               brkREQ, weCnt - w0, reCnt - r0);
    end
  endtask

  task automatic test_reset_rdw();
    int r0; int seen;
    brkGNT = 1'b1;
    r0 = reCnt; seen = 0;
    @(negedge clk);
    dmaRD = 1'b1; dmaWR = 1'b0; dmaADDR = 15'o07777; dmaDOUT = '0; dmaREQ = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (memRE) begin
        seen = 1;
        break;
      end
    end
    @(negedge clk);
    checks++;
    if (seen != 1 || dbgState !== 3'd3) begin
      errors++;
      $display("FAIL reset_rdw_entry: got memRE %0d state %0d expected 1/3", seen, dbgState);
    end
    #1;
    reset = 1'b0; dmaREQ = 1'b0;
    #1;
    checks++;
    if ({brkREQ, dmaGNT, memWE, memRE} !== 4'b0 || dbgState !== 3'd0) begin
      errors++;
      $display("FAIL reset_rdw_async: got %b state %0d expected 0000/0",
               {brkREQ, dmaGNT, memWE, memRE}, dbgState);
    end
    checks++;
    if (dmaDIN !== 12'o0 || xferCNT !== 12'o0 || memADDR !== 15'o0) begin
      errors++;
      $display("FAIL reset_rdw_regs: got din %o cnt %o addr %o expected 0/0/0",
               dmaDIN, xferCNT, memADDR);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (reCnt - r0 !== 1 || dmaDIN !== 12'o0) begin
      errors++;
      $display("FAIL reset_rdw_abandon: got re %0d din %o expected 1/0", reCnt - r0, dmaDIN);
    end
  endtask

  task automatic test_back_to_back();
    int lat; int brk; bit got; bit ok;
    logic [0:14] a; logic [0:11] d;
    logic [26:0] e; logic [26:0] o;
    brkGNT = 1'b1;
    for (int n = 1; n <= 4097; n++) begin
      a = 15'($urandom_range(0, 32767));
      d = 12'($urandom_range(0, 4095));
      expQ.push_back({a, d});
      do_req(1'b0, 1'b1, a, d, lat, brk, got);
      checks++;
      if (!got || lat !== 4) begin
        errors++;
        $display("FAIL b2b_latency[%0d]: got %0d (grant %0d) expected 4", n, lat, got);
      end
      drop_req(ok);
      e = expQ.pop_front();
      checks++;
      if (obsQ.size() == 0) begin
        errors++;
        $display("FAIL b2b_data[%0d]: got no write expected %o", n, e);
      end else begin
        o = obsQ.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL b2b_data[%0d]: got %o expected %o", n, o, e);
        end
      end
      if (n == 4095) begin
        checks++;
        if (xferCNT !== 12'o7777) begin
          errors++;
          $display("FAIL b2b_cnt_max: got %o expected 7777", xferCNT);
        end
      end
      if (n == 4096) begin
        checks++;
        if (xferCNT !== 12'o0000) begin
          errors++;
          $display("FAIL b2b_cnt_wrap: got %o expected 0000", xferCNT);
        end
      end
    end
    checks++;
    if (xferCNT !== 12'o0001) begin
      errors++;
      $display("FAIL b2b_cnt_final: got %o expected 0001", xferCNT);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_error();
    test_early_drop();
    test_clear();
    test_reset_rdw();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (bothCnt !== 0) begin
      errors++;
      $display("FAIL strobe_overlap: got %0d cycles with memWE and memRE expected 0", bothCnt);
    end
    checks++;
    if (obsQ.size() !== 0 || expQ.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got obs %0d exp %0d expected 0/0",
               obsQ.size(), expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rk8e_dma_bridge.md
RK8E_DMA_BRIDGE -- requirements
Module: rk8e_dma_bridge

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 1024, max clk cycles to wait for brkGNT before aborting a transfer.
REQ-002 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have ports: reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have ports: clear  in  1  synchronous IOCLR, active-high.
REQ-005 SHALL have ports: dmaREQ in 1, dmaRD in 1, dmaWR in 1, dmaADDR in [0:14], dmaDOUT in [0:12); all are the disk-side DMA request, memory-read, memory-write, address and write-data.
REQ-006 SHALL have ports: dmaGNT out 1 (grant to disk), dmaDIN out [0:11] (memory read data to disk).
REQ-007 SHALL have ports: brkREQ out 1 (break-cycle request to CPU), brkGNT in 1 (CPU grants memory bus).
REQ-008 SHALL have ports: memADDR out [0:14], memWDATA out [0:11], memWE out 1, memRE out 1, memRDATA in [0:11] (synchronous RAM, read data valid exactly 1 cycle after memRE).
REQ-009 SHALL have ports: dmaERR out 1 (sticky protocol error), dmaTMO out 1 (sticky timeout), xferCNT out [0:11] (completed-transfer count).

Function
REQ-010 SHALL implement FSM states IDLE, BRK, MEM, RDW, ACK.
REQ-011 IDLE: on dmaREQ=1, latch dmaADDR, dmaDOUT, dmaRD, dmaWR and go to BRK; one request per 4-phase handshake.
REQ-012 IDLE with dmaREQ=1 and dmaRD==dmaWR (both 0 or both 1): set dmaERR, no memory access, go directly to ACK.
REQ-013 BRK: brkREQ=1; on brkGNT=1 go to MEM; a timeout counter counts BRK cycles.
REQ-014 BRK: when the counter reaches TIMEOUT with no brkGNT, set dmaTMO, drop brkREQ, go to ACK without memory access.
REQ-015 MEM (exactly 1 cycle): memADDR=latched address; write: memWE=1, memWDATA=latched data, go to ACK; read: memRE=1, go to RDW.
REQ-016 RDW (exactly 1 cycle): capture memRDATA into dmaDIN register, go to ACK.
REQ-017 brkREQ SHALL remain 1 during BRK, MEM and RDW, and drop on entry to ACK.
REQ-018 ACK: dmaGNT=1 held until dmaREQ=0, then dmaGNT=0 and return to IDLE; IDLE SHALL last at least 1 cycle (dmaGNT low ≥1 cycle between grants).
REQ-019 dmaDIN SHALL hold its value from the last successful read until the next successful read; aborted or erroneous requests do not change it.
REQ-020 xferCNT SHALL increment by 1 on each MEM-state cycle only, 12-bit, wrap 7777 -> 0000.
REQ-021 memWE and memRE SHALL never both be 1; both SHALL be 0 outside MEM.
REQ-022 Request latency: dmaREQ rising with brkGNT already 1 -> write: dmaGNT=1 four cycles after dmaREQ is sampled; read: five cycles.
REQ-023 clear=1 SHALL force IDLE, drop brkREQ/dmaGNT/memWE/memRE, zero dmaERR, dmaTMO, xferCNT, timeout counter; clear wins over all other events in the same cycle.
REQ-024 dmaREQ dropping before ACK SHALL not abort the in-flight transfer; ACK then sees dmaREQ=0 and returns to IDLE after one dmaGNT=1 cycle.

Reset
REQ-025 While reset=0: state IDLE, brkREQ=0, dmaGNT=0, memWE=0, memRE=0, memADDR=0, memWDATA=0, dmaDIN=0, dmaERR=0, dmaTMO=0, xferCNT=0, timeout counter=0.
REQ-026 reset SHALL take effect asynchronously; release is sampled on the next rising clk edge; reset mid-transfer abandons it with no further memory strobe.

Verification
REQ-027 Write: dmaWR=1, dmaADDR=00100, dmaDOUT=5252, brkGNT=1 -> one memWE pulse at 00100 data 5252, dmaGNT until dmaREQ=0, xferCNT=0001.
REQ-028 Read: memory returns 1234 at 07777, dmaRD=1 -> memRE one cycle, dmaDIN=1234 when dmaGNT rises, xferCNT increments.
REQ-029 Timeout: TIMEOUT=16, brkGNT held 0 -> brkREQ drops after 16 cycles, dmaTMO=1, dmaGNT=1, no memWE/memRE, xferCNT unchanged.
REQ-030 Error: dmaRD=dmaWR=1 -> dmaERR=1, no brkREQ, dmaGNT handshake completes; dmaDIN unchanged.
REQ-031 Clear in BRK and reset in RDW -> outputs return to REQ-023/REQ-025 values next cycle or immediately; 4097 back-to-back writes -> xferCNT=0001 (wrap).
